// File: rtl/POLI_types_pkg.sv
// Shared POLI types: CRC register offsets, CONTROL/STATUS bit indices,
// the CRC engine state type and a byte bit-reversal helper.
package POLI_types_pkg;

  localparam logic [31:0] CRC_CONTROL_ADDR = 32'h0000_0018;
  localparam logic [31:0] CRC_STATUS_ADDR  = 32'h0000_001C;
  localparam logic [31:0] CRC_INPUT_ADDR   = 32'h0000_0020;
  localparam logic [31:0] CRC_OUTPUT_ADDR  = 32'h0000_0024;
  localparam logic [31:0] CRC_INPUT8_ADDR  = 32'h0000_0028;

  localparam int CTRL_CLEAR_BIT   = 0;
  localparam int CTRL_REFLECT_BIT = 1;
  localparam int CTRL_IRQ_EN_BIT  = 2;

  localparam int STAT_BUSY_BIT    = 0;
  localparam int STAT_PENDING_BIT = 1;
  localparam int STAT_DONE_BIT    = 2;
  localparam int STAT_OVERRUN_BIT = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } crc_state_t;

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[7-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/poli_crc_engine_if.sv
// Simple POLI register bus as seen by the CRC peripheral.
interface poli_crc_engine_if;
  logic [31:0] addr;
  logic        wen;
  logic        ren;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (output addr, output wen, output ren, output wdata,
                  input rdata, input irq);
  modport slave  (input addr, input wen, input ren, input wdata,
                  output rdata, output irq);
endinterface

// File: rtl/poli_crc_step.sv
// Combinational CRC advance: BITS_PER_CYCLE serial MSB-first LFSR steps.
// bits_i[BITS_PER_CYCLE-1] is consumed first.
module poli_crc_step #(
  parameter int          CRC_WIDTH      = 32,
  parameter int          BITS_PER_CYCLE = 1,
  parameter logic [31:0] POLY           = 32'h04C11DB7
) (
  input  logic [CRC_WIDTH-1:0]      crc_i,
  input  logic [BITS_PER_CYCLE-1:0] bits_i,
  output logic [CRC_WIDTH-1:0]      crc_o
);

  always_comb begin
    logic [CRC_WIDTH-1:0] c;
    logic                 fb;
    c  = crc_i;
    fb = 1'b0;
    for (int i = BITS_PER_CYCLE - 1; i >= 0; i--) begin
      fb = c[CRC_WIDTH-1] ^ bits_i[i];
      c  = {c[CRC_WIDTH-2:0], 1'b0} ^ ({CRC_WIDTH{fb}} & POLY[CRC_WIDTH-1:0]);
    end
    crc_o = c;
  end

endmodule

// File: rtl/poli_crc_engine.sv
// Register-mapped CRC peripheral: address decode, CONTROL/STATUS, one-entry
// holding buffer, shift counter and IDLE/RUN sequencer around poli_crc_step.
module poli_crc_engine
  import POLI_types_pkg::*;
#(
  parameter int          CRC_WIDTH      = 32,
  parameter logic [31:0] POLY           = 32'h04C11DB7,
  parameter logic [31:0] INIT           = 32'hFFFFFFFF,
  parameter logic [31:0] XOR_OUT        = 32'hFFFFFFFF,
  parameter int          BITS_PER_CYCLE = 1,
  parameter logic [31:0] BASE_ADDR      = 32'h00ff0000
) (
  input  logic        clk,
  input  logic        rst,
  poli_crc_engine_if.slave bus
);

  localparam logic [31:0] A_CTRL = BASE_ADDR + CRC_CONTROL_ADDR;
  localparam logic [31:0] A_STAT = BASE_ADDR + CRC_STATUS_ADDR;
  localparam logic [31:0] A_IN   = BASE_ADDR + CRC_INPUT_ADDR;
  localparam logic [31:0] A_OUT  = BASE_ADDR + CRC_OUTPUT_ADDR;
  localparam logic [31:0] A_IN8  = BASE_ADDR + CRC_INPUT8_ADDR;
  localparam logic [5:0]  WORD_CNT = 6'(32 / BITS_PER_CYCLE);
  localparam logic [5:0]  BYTE_CNT = 6'(8 / BITS_PER_CYCLE);

  crc_state_t           state_q, state_d;
  logic [CRC_WIDTH-1:0] crc_q, crc_d, crc_step_s, crc_rev_s, out_s;
  logic [31:0]          shift_q, shift_d;
  logic [5:0]           cnt_q, cnt_d;
  logic                 buf_full_q, buf_full_d, buf_byte_q, buf_byte_d;
  logic [31:0]          buf_data_q, buf_data_d;
  logic                 reflect_q, reflect_d, irq_en_q, irq_en_d;
  logic                 done_q, done_d, overrun_q, overrun_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 irq_q;

  logic wr_ctrl_s, wr_stat_s, wr_in_s, wr_in8_s, item_wr_s, clear_s, start_s;
  logic [31:0] src_data_s;
  logic        src_byte_s;

  // Byte0 enters the stream first; REFLECT feeds each byte LSB-first.
  function automatic logic [31:0] make_stream(input logic [31:0] d,
                                              input logic is_byte,
                                              input logic refl);
    logic [31:0] s;
    logic [7:0]  b;
    s = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      b = refl ? rev8(d[8*i +: 8]) : d[8*i +: 8];
      if (!is_byte || i == 0) begin
        s[31-8*i -: 8] = b;
      end
    end
    return s;
  endfunction

  assign wr_ctrl_s = bus.wen && (bus.addr == A_CTRL);
  assign wr_stat_s = bus.wen && (bus.addr == A_STAT);
  assign wr_in_s   = bus.wen && (bus.addr == A_IN);
  assign wr_in8_s  = bus.wen && (bus.addr == A_IN8);
  assign item_wr_s = wr_in_s || wr_in8_s;
  assign clear_s   = wr_ctrl_s && bus.wdata[CTRL_CLEAR_BIT];

  // A new item always comes from the buffer when it holds one.
  assign src_data_s = buf_full_q ? buf_data_q : bus.wdata;
  assign src_byte_s = buf_full_q ? buf_byte_q : wr_in8_s;

  poli_crc_step #(
    .CRC_WIDTH      (CRC_WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE),
    .POLY           (POLY)
  ) u_step (
    .crc_i  (crc_q),
    .bits_i (shift_q[31 -: BITS_PER_CYCLE]),
    .crc_o  (crc_step_s)
  );

  always_comb begin
    for (int i = 0; i < CRC_WIDTH; i++) begin
      crc_rev_s[i] = crc_q[CRC_WIDTH-1-i];
    end
  end

  assign out_s = (reflect_q ? crc_rev_s : crc_q) ^ XOR_OUT[CRC_WIDTH-1:0];

  always_comb begin
    state_d    = state_q;
    crc_d      = crc_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    buf_full_d = buf_full_q;
    buf_data_d = buf_data_q;
    buf_byte_d = buf_byte_q;
    reflect_d  = reflect_q;
    irq_en_d   = irq_en_q;
    done_d     = done_q;
    overrun_d  = overrun_q;
    rdata_d    = rdata_q;
    start_s    = 1'b0;

    if (wr_ctrl_s) begin
      reflect_d = bus.wdata[CTRL_REFLECT_BIT];
      irq_en_d  = bus.wdata[CTRL_IRQ_EN_BIT];
    end
    // W1C first so that hardware sets below take precedence.
    if (wr_stat_s) begin
      done_d    = done_q    & ~bus.wdata[STAT_DONE_BIT];
      overrun_d = overrun_q & ~bus.wdata[STAT_OVERRUN_BIT];
    end

    if (clear_s) begin
      crc_d      = INIT[CRC_WIDTH-1:0];
      state_d    = IDLE;
      buf_full_d = 1'b0;
      cnt_d      = 6'd0;
      shift_d    = 32'h0000_0000;
    end else begin
      case (state_q)
        IDLE: begin
          if (buf_full_q || item_wr_s) begin
            start_s    = 1'b1;
            buf_full_d = buf_full_q && item_wr_s;
          end
        end
        RUN: begin
          crc_d   = crc_step_s;
          shift_d = shift_q << BITS_PER_CYCLE;
          cnt_d   = cnt_q - 6'd1;
          if (cnt_q == 6'd1) begin
            if (buf_full_q) begin
              start_s    = 1'b1;
              buf_full_d = item_wr_s;
            end else begin
              state_d    = IDLE;
              done_d     = 1'b1;
              buf_full_d = item_wr_s;
            end
          end else if (item_wr_s) begin
            if (buf_full_q) begin
              overrun_d = 1'b1;
            end else begin
              buf_full_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      if (start_s) begin
        state_d = RUN;
        shift_d = make_stream(src_data_s, src_byte_s, reflect_q);
        cnt_d   = src_byte_s ? BYTE_CNT : WORD_CNT;
      end
      // Capture the incoming item whenever the buffer is (re)filled by it.
      if (item_wr_s && buf_full_d && !(buf_full_q && !start_s)) begin
        buf_data_d = bus.wdata;
        buf_byte_d = wr_in8_s;
      end
    end

    if (bus.ren) begin
      case (bus.addr)
        A_CTRL:  rdata_d = {29'd0, irq_en_q, reflect_q, 1'b0};
        A_STAT:  rdata_d = {28'd0, overrun_q, done_q, buf_full_q, (state_q == RUN)};
        A_OUT:   rdata_d = 32'(out_s);
        default: rdata_d = 32'h0000_0000;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      crc_q      <= INIT[CRC_WIDTH-1:0];
      shift_q    <= 32'h0000_0000;
      cnt_q      <= 6'd0;
      buf_full_q <= 1'b0;
      buf_data_q <= 32'h0000_0000;
      buf_byte_q <= 1'b0;
      reflect_q  <= 1'b0;
      irq_en_q   <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
      rdata_q    <= 32'h0000_0000;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      crc_q      <= crc_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      buf_full_q <= buf_full_d;
      buf_data_q <= buf_data_d;
      buf_byte_q <= buf_byte_d;
      reflect_q  <= reflect_d;
      irq_en_q   <= irq_en_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
      rdata_q    <= rdata_d;
      irq_q      <= done_d && irq_en_d;
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.irq   = irq_q;

endmodule

// File: tb/tb_poli_crc_engine.sv
// Directed bench for poli_crc_engine: one instance at 1 bit/cycle, one at
// 8 bits/cycle, sharing the stimulus bus; tgt selects which one is addressed.
module tb_poli_crc_engine;
  import POLI_types_pkg::*;

  localparam logic [31:0] BASE = 32'h00ff0000;
  localparam logic [31:0] WA   = 32'h34333231;
  localparam logic [31:0] WB   = 32'h38373635;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr_r, wdata_r;
  logic        wen_r, ren_r;
  logic        tgt;
  int          n_vec = 0;
  int          n_miss = 0;
  logic [7:0]  msg [0:8] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
  logic [7:0]  nine [0:8] = '{8'h39, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  always #5 clk = ~clk;

  poli_crc_engine_if bus1();
  poli_crc_engine_if bus8();

  assign bus1.addr  = addr_r;
  assign bus1.wdata = wdata_r;
  assign bus1.wen   = wen_r & ~tgt;
  assign bus1.ren   = ren_r & ~tgt;
  assign bus8.addr  = addr_r;
  assign bus8.wdata = wdata_r;
  assign bus8.wen   = wen_r & tgt;
  assign bus8.ren   = ren_r & tgt;

  poli_crc_engine #(.BITS_PER_CYCLE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  poli_crc_engine #(.BITS_PER_CYCLE(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  // Textbook CRC-32: reflected right-shift form or normal left-shift form.
  function automatic logic [31:0] crc_ref(input logic [7:0] bytes [0:8], input int n, input bit refl);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      if (refl) begin
        c = c ^ {24'd0, bytes[i]};
        for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end else begin
        c = c ^ {bytes[i], 24'd0};
        for (int k = 0; k < 8; k++) c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
      end
    end
    return ~c;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d);
    addr_r = BASE + off; wdata_r = d; wen_r = 1'b1;
    cyc();
    wen_r = 1'b0;
  endtask

  task automatic rd(input logic [31:0] off, output logic [31:0] d);
    addr_r = BASE + off; ren_r = 1'b1;
    cyc();
    ren_r = 1'b0;
    d = tgt ? bus8.rdata : bus1.rdata;
  endtask

  task automatic wait_stat(input logic [31:0] mask, input logic [31:0] val, input int max_cyc, input string tag);
    logic [31:0] st;
    st = 32'h0;
    for (int i = 0; i < max_cyc; i++) begin
      rd(CRC_STATUS_ADDR, st);
      if ((st & mask) == val) break;
    end
    check_eq(tag, st & mask, val);
  endtask

  // Feeds "123456789" as two words and a byte, waiting for the buffer to drain.
  task automatic run_msg(input string tag);
    wr(CRC_INPUT_ADDR, WA);
    wr(CRC_INPUT_ADDR, WB);
    wait_stat(32'h2, 32'h0, 80, {tag, "_drain"});
    wr(CRC_INPUT8_ADDR, 32'h39);
    wait_stat(32'h4, 32'h4, 120, {tag, "_done"});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    rst = 1'b1; addr_r = 32'h0; wdata_r = 32'h0; wen_r = 1'b0; ren_r = 1'b0; tgt = 1'b0;
    repeat (2) cyc();
    rst = 1'b0;

    check_eq("rst_rdata", bus1.rdata, 32'h0);
    check_eq("rst_irq", {31'd0, bus1.irq}, 32'h0);
    rd(CRC_STATUS_ADDR, d);  check_eq("rst_status", d, 32'h0);
    rd(CRC_CONTROL_ADDR, d); check_eq("rst_control", d, 32'h0);
    rd(CRC_OUTPUT_ADDR, d);  check_eq("rst_output", d, 32'h0);

    // Reflected CRC-32 of "123456789"
    wr(CRC_CONTROL_ADDR, 32'h3);
    rd(CRC_CONTROL_ADDR, d); check_eq("ctrl_readback", d, 32'h2);
    wr(CRC_INPUT_ADDR, WA);
    wr(CRC_INPUT_ADDR, WB);
    rd(CRC_STATUS_ADDR, d);  check_eq("pending_set", d, 32'h3);
    wait_stat(32'h2, 32'h0, 80, "refl_drain");
    wr(CRC_INPUT8_ADDR, 32'h39);
    wait_stat(32'h4, 32'h4, 120, "refl_done");
    rd(CRC_OUTPUT_ADDR, d);  check_eq("crc_refl", d, 32'hCBF43926);

    wr(CRC_STATUS_ADDR, 32'h4);
    wr(CRC_CONTROL_ADDR, 32'h1);
    run_msg("norm");
    rd(CRC_OUTPUT_ADDR, d);  check_eq("crc_norm", d, 32'hFC891918);

    // 8 bits per cycle: DONE exactly 4 cycles after a word write
    tgt = 1'b1;
    wr(CRC_CONTROL_ADDR, 32'h5);
    wr(CRC_INPUT_ADDR, WA);
    repeat (3) cyc();
    check_eq("b8_irq_early", {31'd0, bus8.irq}, 32'h0);
    cyc();
    check_eq("b8_done_lat", {31'd0, bus8.irq}, 32'h1);
    wr(CRC_INPUT_ADDR, WB);
    repeat (4) cyc();
    wr(CRC_INPUT8_ADDR, 32'h39);
    repeat (2) cyc();
    rd(CRC_OUTPUT_ADDR, d);  check_eq("b8_crc", d, 32'hFC891918);
    tgt = 1'b0;

    // Third back-to-back write overruns and is dropped
    wr(CRC_STATUS_ADDR, 32'hC);
    wr(CRC_CONTROL_ADDR, 32'h1);
    wr(CRC_INPUT_ADDR, WA);
    wr(CRC_INPUT_ADDR, WB);
    wr(CRC_INPUT_ADDR, 32'h11223344);
    rd(CRC_STATUS_ADDR, d);  check_eq("ovr_status", d, 32'hB);
    wait_stat(32'h4, 32'h4, 120, "ovr_done");
    rd(CRC_OUTPUT_ADDR, d);  check_eq("ovr_crc", d, crc_ref(msg, 8, 1'b0));
    rd(CRC_STATUS_ADDR, d);  check_eq("ovr_sticky", d, 32'hC);

    // CLEAR mid-run with the buffer full
    wr(CRC_STATUS_ADDR, 32'hC);
    wr(CRC_CONTROL_ADDR, 32'h1);
    wr(CRC_INPUT_ADDR, WA);
    wr(CRC_INPUT_ADDR, WB);
    wr(CRC_CONTROL_ADDR, 32'h1);
    rd(CRC_STATUS_ADDR, d);  check_eq("clr_status", d, 32'h0);
    rd(CRC_OUTPUT_ADDR, d);  check_eq("clr_output", d, 32'h0);
    repeat (40) cyc();
    rd(CRC_STATUS_ADDR, d);  check_eq("clr_quiet", d, 32'h0);

    // DONE W1C landing on the completion edge: set wins
    wr(CRC_CONTROL_ADDR, 32'h5);
    wr(CRC_INPUT8_ADDR, 32'h39);
    repeat (7) cyc();
    wr(CRC_STATUS_ADDR, 32'h4);
    rd(CRC_STATUS_ADDR, d);  check_eq("w1c_race", d, 32'h4);
    check_eq("w1c_irq_hold", {31'd0, bus1.irq}, 32'h1);
    rd(CRC_OUTPUT_ADDR, d);  check_eq("crc_byte", d, crc_ref(nine, 1, 1'b0));
    wr(CRC_STATUS_ADDR, 32'h4);
    check_eq("w1c_irq_clr", {31'd0, bus1.irq}, 32'h0);
    rd(CRC_STATUS_ADDR, d);  check_eq("w1c_status", d, 32'h0);

    rd(32'h0000_0000, d);    check_eq("unmapped_rd", d, 32'h0);
    wr(32'h0000_002C, 32'hFFFFFFFF);
    rd(CRC_CONTROL_ADDR, d); check_eq("unmapped_wr", d, 32'h4);

    // Synchronous reset mid-run drops everything, including the buffer
    wr(CRC_CONTROL_ADDR, 32'h6);
    wr(CRC_INPUT_ADDR, WA);
    wr(CRC_INPUT_ADDR, WB);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check_eq("rst2_rdata", bus1.rdata, 32'h0);
    check_eq("rst2_irq", {31'd0, bus1.irq}, 32'h0);
    rd(CRC_STATUS_ADDR, d);  check_eq("rst2_status", d, 32'h0);
    rd(CRC_CONTROL_ADDR, d); check_eq("rst2_control", d, 32'h0);
    rd(CRC_OUTPUT_ADDR, d);  check_eq("rst2_output", d, 32'h0);
    repeat (40) cyc();
    rd(CRC_STATUS_ADDR, d);  check_eq("rst2_quiet", d, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
